rom_ram_copier: RTL and testbench

- Synchronous block-transfer controller that sits upstream of the RAM register file and downstream of the ROM.
- Reads COUNT words from the ROM starting at SRC_ADDR and writes them into the RAM starting at DST_ADDR.
- Generates all chip-select, output-enable and write-strobe signals, and drives and releases the RAM's bidirectional data bus.
- Optional verify pass reads back each written word and flags mismatches. Used to initialise RAM contents from ROM without testbench $readmemh.

---
 rtl/rom_ram_copier.sv | 164 ++++++++++++++++
 tb/tb_rom_ram_copier.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_ram_copier.sv
// ROM-to-RAM block copier with optional per-word read-back verify.
// Every output comes from a register loaded with the value decoded for the next state.
module rom_ram_copier #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [ADDR_SIZE-1:0] SRC_ADDR,
  input  logic [ADDR_SIZE-1:0] DST_ADDR,
  input  logic [ADDR_SIZE:0]   COUNT,
  input  logic                 VERIFY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [ADDR_SIZE-1:0] ERR_ADDR,
  output logic [ADDR_SIZE-1:0] ROM_ADDR,
  input  logic [DATA_SIZE-1:0] DATA_ROM,
  output logic                 CS_rom,
  output logic                 OE_rom,
  output logic [ADDR_SIZE-1:0] RAM_ADDR,
  inout  wire  [DATA_SIZE-1:0] DATA_RAM,
  output logic                 CS_ram,
  output logic                 OE_ram,
  output logic                 WS
);

  typedef enum logic [2:0] {
    IDLE, ROM_SET, ROM_CAP, RAM_WR, RAM_HLD, RAM_TRN, RAM_RD, FIN
  } state_e;

  localparam logic [ADDR_SIZE:0]   CNT_MAX  = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_SIZE-1:0]   ram_addr_q, ram_addr_d;
  logic [ADDR_SIZE:0]     cnt_q, cnt_d;
  logic                   ver_q, ver_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   err_q, err_d;
  logic [ADDR_SIZE-1:0]   err_addr_q, err_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cs_rom_q, cs_rom_d;
  logic                   oe_rom_q, oe_rom_d;
  logic                   cs_ram_q, cs_ram_d;
  logic                   oe_ram_q, oe_ram_d;
  logic                   ws_q, ws_d;
  logic [ADDR_SIZE:0]     cnt_clamped;

  assign cnt_clamped = (COUNT > CNT_MAX) ? CNT_MAX : COUNT;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    cnt_d      = cnt_q;
    ver_d      = ver_q;
    data_d     = data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          rom_addr_d = SRC_ADDR;
          ram_addr_d = DST_ADDR;
          cnt_d      = cnt_clamped;
          ver_d      = VERIFY;
          err_d      = 1'b0;
          state_d    = (COUNT == '0) ? FIN : ROM_SET;
        end
      end
      ROM_SET: state_d = ROM_CAP;
      ROM_CAP: begin
        data_d  = DATA_ROM;
        state_d = RAM_WR;
      end
      RAM_WR:  state_d = RAM_HLD;
      RAM_HLD: state_d = ver_q ? RAM_TRN : ROM_SET;
      RAM_TRN: state_d = RAM_RD;
      RAM_RD: begin
        if ((DATA_RAM != data_q) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = ram_addr_q;
        end
        state_d = ROM_SET;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The word-advance step is shared by the last state of both the plain and the verify sequence.
    if ((state_q == RAM_HLD && !ver_q) || state_q == RAM_RD) begin
      rom_addr_d = rom_addr_q + ADDR_ONE;
      ram_addr_d = ram_addr_q + ADDR_ONE;
      cnt_d      = cnt_q - CNT_ONE;
      state_d    = (cnt_q == CNT_ONE) ? FIN : ROM_SET;
    end

    busy_d   = state_d inside {ROM_SET, ROM_CAP, RAM_WR, RAM_HLD, RAM_TRN, RAM_RD};
    done_d   = (state_d == FIN);
    cs_rom_d = !(state_d inside {ROM_SET, ROM_CAP});
    oe_rom_d = state_d inside {ROM_SET, ROM_CAP};
    cs_ram_d = !(state_d inside {RAM_WR, RAM_RD});
    oe_ram_d = (state_d == RAM_RD);
    ws_d     = !(state_d inside {RAM_WR, RAM_HLD});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      cnt_q      <= '0;
      ver_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_rom_q   <= 1'b1;
      oe_rom_q   <= 1'b0;
      cs_ram_q   <= 1'b1;
      oe_ram_q   <= 1'b0;
      ws_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      cnt_q      <= cnt_d;
      ver_q      <= ver_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_rom_q   <= cs_rom_d;
      oe_rom_q   <= oe_rom_d;
      cs_ram_q   <= cs_ram_d;
      oe_ram_q   <= oe_ram_d;
      ws_q       <= ws_d;
    end
  end

  // The bus enable is the write strobe itself, so the bus can never be driven while WS=1.
  assign DATA_RAM = ws_q ? 'z : data_q;

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_ADDR = err_addr_q;
  assign ROM_ADDR = rom_addr_q;
  assign RAM_ADDR = ram_addr_q;
  assign CS_rom   = cs_rom_q;
  assign OE_rom   = oe_rom_q;
  assign CS_ram   = cs_ram_q;
  assign OE_ram   = oe_ram_q;
  assign WS       = ws_q;

endmodule

// File: tb/tb_rom_ram_copier.sv
// Directed bench for rom_ram_copier: ROM/RAM models, write scoreboard and bus-rule monitor.
module tb_rom_ram_copier;

  logic       CLK, RST, START, VERIFY;
  logic [4:0] SRC_ADDR, DST_ADDR;
  logic [5:0] COUNT;
  logic       BUSY, DONE, ERR;
  logic [4:0] ERR_ADDR, ROM_ADDR, RAM_ADDR;
  logic [7:0] DATA_ROM;
  logic       CS_rom, OE_rom, CS_ram, OE_ram, WS;
  wire  [7:0] data_ram;

  rom_ram_copier #(.DATA_SIZE(8), .ADDR_SIZE(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .COUNT(COUNT), .VERIFY(VERIFY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ERR_ADDR(ERR_ADDR), .ROM_ADDR(ROM_ADDR), .DATA_ROM(DATA_ROM), .CS_rom(CS_rom),
    .OE_rom(OE_rom), .RAM_ADDR(RAM_ADDR), .DATA_RAM(data_ram), .CS_ram(CS_ram),
    .OE_ram(OE_ram), .WS(WS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] rom [32];
  logic [7:0] ram [32];
  logic       stuck_en;
  logic       ram_drv;
  logic [7:0] rd_val;

  assign DATA_ROM = (!CS_rom && OE_rom) ? rom[ROM_ADDR] : 8'h00;
  assign ram_drv  = !CS_ram && OE_ram && WS;

  always_comb begin
    rd_val = ram[RAM_ADDR];
    if (stuck_en && RAM_ADDR == 5'd9) rd_val[0] = 1'b0;
  end

  assign data_ram = ram_drv ? rd_val : 8'hzz;

  always @(posedge CLK)
    if (!CS_ram && !WS) ram[RAM_ADDR] <= data_ram;

  typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int unsigned n_total = 0, n_pass = 0;
  int unsigned busy_cnt = 0, done_cnt = 0, cs_viol = 0, bus_viol = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Under 2-state simulation an undriven net reads as 0 rather than z.
  function automatic logic bus_idle(input logic [7:0] v);
    return (v === 8'h00) || (v === 8'hzz);
  endfunction

  always @(negedge CLK) begin
    if (mon_en) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      if (!CS_rom && !CS_ram) cs_viol++;
      if (WS && !ram_drv && !bus_idle(data_ram)) bus_viol++;
      if (!CS_ram && !WS) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {27'd0, RAM_ADDR}, {27'd0, e.addr});
          check("wr_data", {24'd0, data_ram}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic run(input logic [4:0] s, input logic [4:0] d, input logic [5:0] c,
                     input logic v, input logic hold);
    int unsigned n, busy_base, done_base;
    n = (c > 6'd32) ? 32 : int'(c);
    for (int unsigned i = 0; i < n; i++) begin
      wr_t e;
      logic [4:0] ra;
      ra = s + 5'(i);
      e.addr = d + 5'(i);
      e.data = rom[ra];
      exp_q.push_back(e);
    end
    busy_base = busy_cnt;
    done_base = done_cnt;
    SRC_ADDR = s; DST_ADDR = d; COUNT = c; VERIFY = v; START = 1'b1;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    check("err_cleared_on_start", {31'd0, ERR}, 32'd0);
    for (int unsigned k = 0; k < 6 * n + 20 && done_cnt == done_base; k++) @(negedge CLK);
    START = 1'b0;
    check("done_seen", {31'd0, done_cnt != done_base}, 32'd1);
    repeat (2) @(negedge CLK);
    check("done_once", done_cnt - done_base, 32'd1);
    check("busy_cycles", busy_cnt - busy_base, (v ? 32'd6 : 32'd4) * n);
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned busy_base, done_base;
    for (int i = 0; i < 32; i++) rom[i] = 8'hA0 + 8'(i);
    stuck_en = 1'b0;
    RST = 1'b1; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; COUNT = '0; VERIFY = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_err_addr", {27'd0, ERR_ADDR}, 32'd0);
    check("rst_rom_addr", {27'd0, ROM_ADDR}, 32'd0);
    check("rst_ram_addr", {27'd0, RAM_ADDR}, 32'd0);
    check("rst_cs_rom", {31'd0, CS_rom}, 32'd1);
    check("rst_oe_rom", {31'd0, OE_rom}, 32'd0);
    check("rst_cs_ram", {31'd0, CS_ram}, 32'd1);
    check("rst_oe_ram", {31'd0, OE_ram}, 32'd0);
    check("rst_ws", {31'd0, WS}, 32'd1);
    check("rst_bus_idle", {31'd0, bus_idle(data_ram)}, 32'd1);
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    // Basic copy with START held high for the whole transfer.
    run(5'd0, 5'd4, 6'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) check("basic_ram", {24'd0, ram[4 + i]}, 32'hA0 + 32'(i));
    check("basic_err", {31'd0, ERR}, 32'd0);

    // Both address counters wrap.
    run(5'd30, 5'd29, 6'd4, 1'b0, 1'b0);
    check("wrap_ram29", {24'd0, ram[29]}, 32'hBE);
    check("wrap_ram30", {24'd0, ram[30]}, 32'hBF);
    check("wrap_ram31", {24'd0, ram[31]}, 32'hA0);
    check("wrap_ram0", {24'd0, ram[0]}, 32'hA1);

    // Verify pass with bit 0 stuck low on reads of address 9.
    stuck_en = 1'b1;
    run(5'd0, 5'd8, 6'd3, 1'b1, 1'b0);
    stuck_en = 1'b0;
    check("verify_err", {31'd0, ERR}, 32'd1);
    check("verify_err_addr", {27'd0, ERR_ADDR}, 32'd9);

    run(5'd5, 5'd12, 6'd2, 1'b1, 1'b0);
    check("verify_clean_err", {31'd0, ERR}, 32'd0);

    // COUNT=0 completes at once without touching either memory.
    busy_base = busy_cnt; done_base = done_cnt;
    COUNT = 6'd0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("zero_done", {31'd0, DONE}, 32'd1);
    check("zero_busy", {31'd0, BUSY}, 32'd0);
    check("zero_cs_rom", {31'd0, CS_rom}, 32'd1);
    check("zero_cs_ram", {31'd0, CS_ram}, 32'd1);
    @(posedge CLK); #1;
    check("zero_done_drop", {31'd0, DONE}, 32'd0);
    check("zero_busy_cycles", busy_cnt - busy_base, 32'd0);
    check("zero_done_count", done_cnt - done_base, 32'd1);

    // Oversized COUNT clamps to the full memory.
    run(5'd3, 5'd0, 6'd40, 1'b0, 1'b0);

    // Reset during the write of the second word.
    for (int unsigned i = 0; i < 4; i++) begin
      wr_t e;
      e.addr = 5'd24 + 5'(i);
      e.data = rom[5'd20 + 5'(i)];
      exp_q.push_back(e);
    end
    SRC_ADDR = 5'd20; DST_ADDR = 5'd24; COUNT = 6'd4; VERIFY = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) @(posedge CLK); #1;
    check("mid_in_ram_wr", {30'd0, CS_ram, WS}, 32'd0);
    check("mid_ram_addr", {27'd0, RAM_ADDR}, 32'd25);
    RST = 1'b1;
    @(posedge CLK); #1;
    exp_q.delete();
    check("mid_rst_cs_ram", {31'd0, CS_ram}, 32'd1);
    check("mid_rst_ws", {31'd0, WS}, 32'd1);
    check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    check("mid_rst_done", {31'd0, DONE}, 32'd0);
    check("mid_rst_bus_idle", {31'd0, bus_idle(data_ram)}, 32'd1);
    busy_base = busy_cnt; done_base = done_cnt;
    RST = 1'b0;
    repeat (10) @(posedge CLK); #1;
    check("mid_no_done", done_cnt - done_base, 32'd0);
    check("mid_no_busy", busy_cnt - busy_base, 32'd0);

    run(5'd10, 5'd16, 6'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check("post_rst_ram", {24'd0, ram[16 + i]}, 32'hAA + 32'(i));

    check("cs_overlap_cycles", cs_viol, 32'd0);
    check("bus_drive_ws1_cycles", bus_viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
